// File: rtl/serv_alu_sequencer_pkg.sv
// Shared types for the bit-serial ALU operand sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
package serv_alu_sequencer_pkg;

  // Sequencer states: one operation walks IDLE -> [INIT -> GAP ->] RUN -> HOLD.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_INIT = 3'd1,
    ST_GAP  = 3'd2,
    ST_RUN  = 3'd3,
    ST_HOLD = 3'd4
  } state_e;

  // True in the states that shift operand bits out to the ALU.
  function automatic logic is_pass(input state_e s);
    return (s == ST_INIT) || (s == ST_RUN);
  endfunction

endpackage

// File: rtl/serv_alu_sequencer_if.sv
// Operation request, serial ALU and writeback signals of the sequencer.
// Latency: n/a (wiring only).
// Backpressure: i_valid/o_ready on the request, o_rd_valid/i_rd_ready on writeback.
//   slave  : the sequencer's view (i_* in, o_* out)
//   master : the requester / ALU / writeback view
interface serv_alu_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             i_valid;
  logic             o_ready;
  logic             i_two_stage;
  logic             i_op_b_sel;
  logic [WIDTH-1:0] i_rs1;
  logic [WIDTH-1:0] i_rs2;
  logic [WIDTH-1:0] i_imm;
  logic             o_en;
  logic             o_init;
  logic             o_cnt_done;
  logic             o_rs1;
  logic             o_op_b;
  logic             i_rd;
  logic             o_rd_valid;
  logic [WIDTH-1:0] o_rd_data;
  logic             i_rd_ready;

  modport slave (
    input  i_valid, i_two_stage, i_op_b_sel, i_rs1, i_rs2, i_imm, i_rd, i_rd_ready,
    output o_ready, o_en, o_init, o_cnt_done, o_rs1, o_op_b, o_rd_valid, o_rd_data
  );

  modport master (
    output i_valid, i_two_stage, i_op_b_sel, i_rs1, i_rs2, i_imm, i_rd, i_rd_ready,
    input  o_ready, o_en, o_init, o_cnt_done, o_rs1, o_op_b, o_rd_valid, o_rd_data
  );
endinterface

// File: rtl/serv_alu_sequencer_ser_rot.sv
// WIDTH-bit rotating operand register: parallel load, rotate right by one, sync clear.
// Latency: loaded value's LSB visible on lsb_o the cycle after load_i.
// Backpressure: none; rotates whenever rot_i is high.
//   clk, clr_i (clear, highest priority), load_i/load_dat_i, rot_i, lsb_o (current bit)
module serv_alu_sequencer_ser_rot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_dat_i,
  input  logic             rot_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] rot_q;

  // LSB wraps into the MSB, so after WIDTH rotations the word is restored.
  always_ff @(posedge clk) begin
    if (clr_i) begin
      rot_q <= '0;
    end else if (load_i) begin
      rot_q <= load_dat_i;
    end else if (rot_i) begin
      rot_q <= {rot_q[0], rot_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = rot_q[0];

endmodule

// File: rtl/serv_alu_sequencer.sv
// Bit-serial operand sequencer and result collector around the serial ALU.
// Latency: result valid WIDTH+1 cycles after accept (single-stage), 2*WIDTH+2 (two-stage).
// Backpressure: result held in HOLD until i_rd_ready; no new accept until back in IDLE.
//   clk, i_rst (sync, active-high); sif.slave carries request, serial ALU and writeback signals.
module serv_alu_sequencer
  import serv_alu_sequencer_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 i_rst,
  serv_alu_sequencer_if.slave  sif
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rd_q, rd_d;

  logic accept;
  logic pass;
  logic last_bit;
  logic rs1_lsb;
  logic op_b_lsb;

  assign accept   = sif.i_valid && (state_q == ST_IDLE);
  assign pass     = is_pass(state_q);
  assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
    end
  end

  // WIDTH is a power of two, so the counter wraps back to 0 on its own
  // at the end of INIT and stays there through the GAP cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rd_d    = rd_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cnt_d   = '0;
          state_d = sif.i_two_stage ? ST_INIT : ST_RUN;
        end
      end
      ST_INIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (last_bit) state_d = ST_GAP;
      end
      ST_GAP: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        // First RUN bit ends up in rd[0] after WIDTH shifts.
        rd_d  = {sif.i_rd, rd_q[WIDTH-1:1]};
        if (last_bit) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (sif.i_rd_ready) state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  serv_alu_sequencer_ser_rot #(.WIDTH(WIDTH)) u_rs1_rot (
    .clk        (clk),
    .clr_i      (i_rst),
    .load_i     (accept),
    .load_dat_i (sif.i_rs1),
    .rot_i      (pass),
    .lsb_o      (rs1_lsb)
  );

  serv_alu_sequencer_ser_rot #(.WIDTH(WIDTH)) u_op_b_rot (
    .clk        (clk),
    .clr_i      (i_rst),
    .load_i     (accept),
    .load_dat_i (sif.i_op_b_sel ? sif.i_imm : sif.i_rs2),
    .rot_i      (pass),
    .lsb_o      (op_b_lsb)
  );

  // Every output decodes from registered state only.
  assign sif.o_ready    = (state_q == ST_IDLE);
  assign sif.o_init     = (state_q == ST_INIT);
  assign sif.o_en       = (state_q == ST_RUN);
  assign sif.o_cnt_done = pass && last_bit;
  assign sif.o_rs1      = pass && rs1_lsb;
  assign sif.o_op_b     = pass && op_b_lsb;
  assign sif.o_rd_valid = (state_q == ST_HOLD);
  assign sif.o_rd_data  = rd_q;

endmodule

// File: tb/tb_serv_alu_sequencer.sv
// Randomized and directed bench for serv_alu_sequencer against a cycle-indexed reference model.
// Latency: n/a.
// Backpressure: exercises held i_rd_ready=0 in HOLD and held i_valid.
module tb_serv_alu_sequencer;

  localparam int W = 32;

  logic clk;
  logic rst;
  logic rd_mode;   // 0: ALU loops rs1 back, 1: ALU returns rs1 ^ op_b

  int n_cmp;
  int n_err;

  serv_alu_sequencer_if #(.WIDTH(W)) sif ();

  serv_alu_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .i_rst (rst),
    .sif   (sif)
  );

  // Combinational stand-in for the serial ALU.
  assign sif.i_rd = rd_mode ? (sif.o_rs1 ^ sif.o_op_b) : sif.o_rs1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Packed control view: {init, en, cnt_done, rs1, op_b, ready, rd_valid}
  function automatic logic [31:0] ctl_now();
    return 32'({sif.o_init, sif.o_en, sif.o_cnt_done, sif.o_rs1, sif.o_op_b,
                sif.o_ready, sif.o_rd_valid});
  endfunction

  // Must be called #1 after an edge while the DUT is in IDLE. Drives one
  // operation, checks every cycle against the timing model and the final result.
  task automatic run_op(input bit two, input bit sel, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm,
                        input bit xmode, input int hold, input bit keep_valid,
                        input int abort_at);
    logic [31:0] opb, res;
    int          run0, last_c, idx;
    logic        e_init, e_en, e_act, e_done, e_rs1, e_opb;

    opb    = sel ? imm : rs2;
    res    = xmode ? (rs1 ^ opb) : rs1;
    run0   = two ? W + 2 : 1;
    last_c = run0 + W - 1;

    sif.i_valid     = 1'b1;
    sif.i_two_stage = two;
    sif.i_op_b_sel  = sel;
    sif.i_rs1       = rs1;
    sif.i_rs2       = rs2;
    sif.i_imm       = imm;
    sif.i_rd_ready  = (hold == 0);
    rd_mode         = xmode;

    @(posedge clk);  // accept edge
    #1;
    if (!keep_valid) sif.i_valid = 1'b0;
    sif.i_rs1 = $urandom;  // operands are don't-care after accept
    sif.i_rs2 = $urandom;
    sif.i_imm = $urandom;

    for (int c = 1; c <= last_c; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      e_init = two && (c <= W);
      e_en   = (c >= run0);
      e_act  = e_init || e_en;
      idx    = e_en ? c - run0 : c - 1;
      e_done = e_act && (idx == W - 1);
      e_rs1  = 1'b0;
      e_opb  = 1'b0;
      if (e_act) begin
        e_rs1 = rs1[idx];
        e_opb = opb[idx];
      end
      chk("ctl", ctl_now(), 32'({e_init, e_en, e_done, e_rs1, e_opb, 1'b0, 1'b0}));
      if (c == abort_at) begin
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sif.i_valid = 1'b0;
        chk("rst_ctl", ctl_now(), 32'b0000010);
        chk("rst_data", sif.o_rd_data, 32'h0);
        return;
      end
    end

    @(posedge clk);
    #1;
    chk("hold_ctl", ctl_now(), 32'b0000001);
    chk("result", sif.o_rd_data, res);
    if (hold > 0) sif.i_valid = 1'b1;  // must be ignored while holding
    for (int h = 1; h <= hold; h++) begin
      @(posedge clk);
      #1;
      chk("bp_ctl", ctl_now(), 32'b0000001);
      chk("bp_data", sif.o_rd_data, res);
    end
    sif.i_rd_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("idle_ctl", ctl_now(), 32'b0000010);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    rd_mode = 1'b0;
    sif.i_valid     = 1'b0;
    sif.i_two_stage = 1'b0;
    sif.i_op_b_sel  = 1'b0;
    sif.i_rs1       = '0;
    sif.i_rs2       = '0;
    sif.i_imm       = '0;
    sif.i_rd_ready  = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_ctl", ctl_now(), 32'b0000010);
    chk("reset_data", sif.o_rd_data, 32'h0);
    rst = 1'b0;

    // Single-stage loopback.
    run_op(1'b0, 1'b0, 32'hDEADBEEF, 32'h12345678, 32'h0, 1'b0, 0, 1'b0, 0);
    // Two-stage timing pattern.
    run_op(1'b1, 1'b0, 32'h80000001, 32'h00000001, 32'hA5A5A5A5, 1'b1, 0, 1'b0, 0);
    // Immediate select plus 10 cycles of writeback backpressure.
    run_op(1'b0, 1'b1, 32'h0F0F1234, 32'h55555555, 32'hFFFFF800, 1'b1, 9, 1'b0, 0);
    // Accept immediately after the backpressured op returns to IDLE.
    run_op(1'b1, 1'b1, 32'hCAFEF00D, 32'h0, 32'h13572468, 1'b1, 0, 1'b0, 0);
    // Reset while presenting RUN bit 10, then a fresh operation.
    run_op(1'b0, 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b0, 0, 1'b0, 11);
    run_op(1'b0, 1'b0, 32'h600DD00D, 32'hFFFF0000, 32'h0, 1'b1, 0, 1'b0, 0);
    // Reset during INIT.
    run_op(1'b1, 1'b0, 32'h7FFFFFFF, 32'h1, 32'h0, 1'b1, 0, 1'b0, 5);
    // Back-to-back with i_valid held high.
    run_op(1'b0, 1'b0, 32'h11112222, 32'h33334444, 32'h0, 1'b1, 0, 1'b1, 0);
    run_op(1'b0, 1'b1, 32'h89ABCDEF, 32'h0, 32'h76543210, 1'b1, 0, 1'b1, 0);
    sif.i_valid = 1'b0;

    // Randomized operations.
    for (int k = 0; k < 12; k++) begin
      run_op(1'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
             1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 0);
    end
    sif.i_valid = 1'b0;

    @(posedge clk);
    #1;
    chk("final_idle", ctl_now(), 32'b0000010);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
